wb_arbiter: RTL
===============

Name: wb_arbiter

Overview:
- Shares the single EXE writeback/forwarding port between up to NUM_FU functional-unit result producers: ALU, MUL, DIV, FALU, FMUL, FDIV and LSU-load.
- Each requester gets a one-entry holding buffer with valid/ready back-pressure.
- A round-robin scheduler grants one result per cycle.
- The granted result drives the combinational forwarding bus, then a registered WB bus one cycle later. Sits between the FU outputs and the ROB/PRF writeback.

Parameters:
- NUM_FU, 8, number of requesters; index = FU select code.
- DATA_W, 32, result data width.
- ROB_W, 3, ROB index width.
- RD_W, 7, physical destination register width.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- fu_valid  input  NUM_FU  result valid per FU
- fu_ready  output  NUM_FU  holding buffer of FU i empty; result can be accepted
- fu_data  input  NUM_FU*DATA_W  packed results; FU i at [i*DATA_W +: DATA_W]
- fu_rob_idx  input  NUM_FU*ROB_W  packed ROB indices
- fu_rd  input  NUM_FU*RD_W  packed destination registers
- flush  input  1  mispredict flush; discard all pending results
- grant  output  NUM_FU  one-hot grant this cycle; 0 if none
- ex_valid  output  1  forwarding bus valid (combinational)
- ex_data  output  DATA_W  forwarding data
- ex_rob_idx  output  ROB_W  forwarding ROB index
- ex_rd  output  RD_W  forwarding destination
- wb_valid  output  1  registered writeback valid
- wb_data  output  DATA_W  registered writeback data
- wb_rob_idx  output  ROB_W  registered writeback ROB index
- wb_rd  output  RD_W  registered writeback destination
- pending_cnt  output  $clog2(NUM_FU+1)  number of occupied holding buffers

Behaviour:
- Reset (rst=0, async):
  - all hold_v=0
  - rr_ptr=0
  - wb_valid=0, wb_data=0, wb_rob_idx=0, wb_rd=0
  - pending_cnt=0
  - fu_ready=all 1s
- Per FU i:
  - fu_ready[i] = ~hold_v[i]
  - req[i] = hold_v[i] | fu_valid[i]
  - candidate = hold_v[i] ? holding entry : live input (bypass, zero added latency)
  - fu_valid[i] while hold_v[i]=1 is ignored; the producer must keep it until ready.
- Arbitration:
  - Scan req starting at rr_ptr, ascending, wrapping NUM_FU-1 -> 0.
  - The first set bit wins; grant is one-hot.
  - On any grant at index g, rr_ptr <= (g+1) mod NUM_FU. With no grant, rr_ptr holds.
- Capture: if fu_valid[i] & ~hold_v[i] & ~grant[i] & ~flush, the holding entry is loaded and hold_v[i] <= 1.
- Release: if grant[i] & hold_v[i] & ~flush, then hold_v[i] <= 0. fu_ready[i] rises the next cycle; there is no same-cycle refill.
- Latency:
  - A live input granted in its arrival cycle appears on ex_* the same cycle and on wb_* the next cycle.
  - A buffered result appears in the cycle it is granted.
- ex_*:
  - ex_valid = |grant & ~flush.
  - ex_data, ex_rob_idx and ex_rd come from the granted candidate; all zero when ex_valid=0.
- wb_*: registered copy of ex_* every cycle.
- Flush:
  - Same cycle: grant is forced to 0 and ex_valid=0.
  - Next edge: all hold_v <= 0, wb_valid <= 0, rr_ptr unchanged. Live inputs presented in the flush cycle are dropped.
- pending_cnt = popcount(hold_v), registered alongside hold_v.
- Boundaries:
  - All NUM_FU requesting: 1 served, NUM_FU-1 buffered, all buffered served within NUM_FU-1 further cycles.
  - rr_ptr wraps from NUM_FU-1 to 0.
  - Reset asserted mid-operation clears everything immediately, independent of clk.

Optional Feature:
- Macro: WB_ARB_FIXED_PRIO_EN
- Defined: rr_ptr is removed and the scan always starts at index 0 (lowest index wins).
  - Integration assigns MUL to the lowest index so long-latency units never stall behind the ALU.
  - Fairness is not guaranteed.
- Undefined: round-robin as above.

Test Plan:
- Reset, then fu_valid[0]=1 with data=0x1234, rob=3, rd=5 for one cycle -> same cycle ex_valid=1, ex_data=0x1234, grant=0x01; next cycle wb_valid=1, wb_rob_idx=3, wb_rd=5, and rr_ptr=1.
- All 8 fu_valid high for one cycle (data=i) with rr_ptr=0 -> grants 0x01,0x02,...,0x80 on 8 consecutive cycles, ex_data 0..7 in order. pending_cnt goes 7,6,...,0. fu_ready[i] is low while FU i is buffered.
- Wrap: rr_ptr=7, fu_valid[7] and fu_valid[2] high -> grant=0x80, then 0x04. rr_ptr becomes 0, then 3.
- FU 1 buffered and held valid with new data=0xBEEF -> 0xBEEF is not accepted until the cycle after the buffered result is granted. No data loss or duplication (scoreboard by rob_idx).
- 3 results buffered, flush=1 for one cycle with fu_valid[4]=1 -> ex_valid=0 and grant=0 that cycle. Next cycle pending_cnt=0, wb_valid=0, fu_ready=0xFF, and the FU 4 result never appears.
- WB_ARB_FIXED_PRIO_EN defined, fu_valid[0] and [5] held high continuously -> FU 0 granted every cycle and FU 5 stays buffered; with the macro undefined, grants alternate 0,5,0,5.

Source files
------------

// File: rtl/wb_arbiter.sv
// Shares one EXE writeback/forwarding port among NUM_FU result producers, one grant per cycle.
// Latency: live result forwarded on ex_* the same cycle, on wb_* one cycle later.
// Backpressure: one-entry hold buffer per FU, fu_ready low while full. `WB_ARB_FIXED_PRIO_EN` selects fixed priority.
module wb_arbiter #(
    parameter int NUM_FU = 8,
    parameter int DATA_W = 32,
    parameter int ROB_W  = 3,
    parameter int RD_W   = 7
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_FU-1:0]             fu_valid,
    output logic [NUM_FU-1:0]             fu_ready,
    input  logic [NUM_FU*DATA_W-1:0]      fu_data,
    input  logic [NUM_FU*ROB_W-1:0]       fu_rob_idx,
    input  logic [NUM_FU*RD_W-1:0]        fu_rd,
    input  logic                          flush,
    output logic [NUM_FU-1:0]             grant,
    output logic                          ex_valid,
    output logic [DATA_W-1:0]             ex_data,
    output logic [ROB_W-1:0]              ex_rob_idx,
    output logic [RD_W-1:0]               ex_rd,
    output logic                          wb_valid,
    output logic [DATA_W-1:0]             wb_data,
    output logic [ROB_W-1:0]              wb_rob_idx,
    output logic [RD_W-1:0]               wb_rd,
    output logic [$clog2(NUM_FU+1)-1:0]   pending_cnt
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int CNT_W = $clog2(NUM_FU + 1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ROB_W-1:0]  rob_idx;
        logic [RD_W-1:0]   rd;
    } res_t;

    res_t              in_res   [NUM_FU];
    res_t              hold_res [NUM_FU];
    res_t              cand     [NUM_FU];
    res_t              ex_res;
    logic [NUM_FU-1:0] hold_v;
    logic [NUM_FU-1:0] hold_v_nxt;
    logic [NUM_FU-1:0] req;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [PTR_W-1:0]  scan_start;
    logic [PTR_W-1:0]  gnt_idx;
    logic              gnt_any;

`ifdef WB_ARB_FIXED_PRIO_EN
    assign scan_start = '0;
`else
    logic [PTR_W-1:0] rr_ptr;
    assign scan_start = rr_ptr;
`endif

    assign fu_ready = ~hold_v;
    assign req      = hold_v | fu_valid;

    // A buffered entry always takes precedence over the live input of the same FU.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            in_res[i].data    = fu_data[i*DATA_W +: DATA_W];
            in_res[i].rob_idx = fu_rob_idx[i*ROB_W +: ROB_W];
            in_res[i].rd      = fu_rd[i*RD_W +: RD_W];
            cand[i]           = hold_v[i] ? hold_res[i] : in_res[i];
        end
    end

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (!gnt_any && req[(int'(scan_start) + k) % NUM_FU]) begin
                gnt_any = 1'b1;
                gnt_idx = PTR_W'((int'(scan_start) + k) % NUM_FU);
            end
        end
    end

    always_comb begin
        grant  = '0;
        ex_res = '0;
        if (gnt_any && !flush) begin
            grant[gnt_idx] = 1'b1;
            ex_res         = cand[gnt_idx];
        end
    end

    assign ex_valid   = |grant;
    assign ex_data    = ex_res.data;
    assign ex_rob_idx = ex_res.rob_idx;
    assign ex_rd      = ex_res.rd;

    // Granted entries leave, ungranted live inputs park; flush empties everything.
    always_comb begin
        hold_v_nxt = hold_v;
        cnt_nxt    = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (flush || grant[i])
                hold_v_nxt[i] = 1'b0;
            else if (fu_valid[i])
                hold_v_nxt[i] = 1'b1;
            cnt_nxt = cnt_nxt + CNT_W'(hold_v_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_v      <= '0;
            pending_cnt <= '0;
            wb_valid    <= 1'b0;
            wb_data     <= '0;
            wb_rob_idx  <= '0;
            wb_rd       <= '0;
            for (int i = 0; i < NUM_FU; i++)
                hold_res[i] <= '0;
`ifndef WB_ARB_FIXED_PRIO_EN
            rr_ptr      <= '0;
`endif
        end else begin
            hold_v      <= hold_v_nxt;
            pending_cnt <= cnt_nxt;
            wb_valid    <= ex_valid;
            wb_data     <= ex_data;
            wb_rob_idx  <= ex_rob_idx;
            wb_rd       <= ex_rd;
            for (int i = 0; i < NUM_FU; i++)
                if (fu_valid[i] && !hold_v[i] && !grant[i] && !flush)
                    hold_res[i] <= in_res[i];
`ifndef WB_ARB_FIXED_PRIO_EN
            if (|grant)
                rr_ptr <= (gnt_idx == PTR_W'(NUM_FU - 1)) ? '0 : gnt_idx + 1'b1;
`endif
        end
    end

endmodule
